// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_pkg
//  Description : Shared types and constants for the program loader: FSM
//                state encoding and the byte/word geometry of a frame.
//  Revision    : 1.0  initial release
// ============================================================================
package program_loader_pkg;

    // Four bytes make up one 32-bit instruction word.
    localparam int BYTES_PER_WORD = 4;

    // Explicit 3-bit encoding so state values are stable in waveforms.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // States in which the loader pulls bytes from the RX path.
    function automatic logic state_accepts_bytes(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_DATA)   || (s == ST_CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_byte_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_byte_word_assembler
//  Description : Places incoming bytes little-endian into a word; byte k of
//                the word lands at bits [8k+7:8k]. Flags the 4th byte.
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader_byte_word_assembler
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [7:0]            i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_complete
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] c_last_byte = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] w_word;

    // Current partial word with the incoming byte dropped into its lane, so
    // the completed word is available in the same cycle as the last byte.
    always_comb begin
        w_word = r_word;
        w_word[8*r_count +: 8] = i_byte;
    end

    assign o_word          = w_word;
    assign o_word_complete = i_valid && (r_count == c_last_byte);

    // Byte lane counter and partial word storage; restart after each word.
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_count <= '0;
            r_word  <= '0;
        end else if (i_valid) begin
            if (r_count == c_last_byte) begin
                r_count <= '0;
                r_word  <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
                r_word  <= w_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Receives a framed byte stream (16-bit length, N words,
//                XOR checksum) and writes the words into program memory at
//                word-aligned byte addresses, holding the core until a frame
//                loads cleanly.
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [15:0] c_max_len = 16'(MEMORY_DEPTH);

    state_t                r_state;
    logic [15:0]           r_len;
    logic [15:0]           r_word_index;
    logic [7:0]            r_checksum;
    logic                  r_mem_write;
    logic [DATA_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_error;

    logic                  w_rx_ready;
    logic                  w_restart;
    logic                  w_data_byte;
    logic [15:0]           w_len_full;
    logic [15:0]           w_next_index;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_complete;
    logic [DATA_WIDTH-1:0] w_word_address;

    assign w_rx_ready     = state_accepts_bytes(r_state);
    assign w_restart      = i_start && ((r_state == ST_IDLE) ||
                                        (r_state == ST_DONE) ||
                                        (r_state == ST_ERROR));
    assign w_data_byte    = i_rx_valid && (r_state == ST_DATA);
    assign w_len_full     = {i_rx_data, r_len[7:0]};
    assign w_next_index   = r_word_index + 16'd1;
    assign w_word_address = DATA_WIDTH'({r_word_index, 2'b00});

    program_loader_byte_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .clk             (clk),
        .reset           (reset),
        .i_clear         (w_restart),
        .i_valid         (w_data_byte),
        .i_byte          (i_rx_data),
        .o_word          (w_word),
        .o_word_complete (w_word_complete)
    );

    // Frame sequencer: length capture, word writes, checksum verdict.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_word_index  <= '0;
            r_checksum    <= '0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_cpu_hold    <= 1'b1;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_mem_write <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        r_state      <= ST_LEN_LO;
                        r_len        <= '0;
                        r_word_index <= '0;
                        r_checksum   <= '0;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_cpu_hold   <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (i_rx_valid) begin
                        r_len[7:0] <= i_rx_data;
                        r_checksum <= r_checksum ^ i_rx_data;
                        r_state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (i_rx_valid) begin
                        r_len      <= w_len_full;
                        r_checksum <= r_checksum ^ i_rx_data;
                        if (w_len_full == 16'd0) begin
                            r_state <= ST_CHECK;
                        end else if (w_len_full > c_max_len) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_rx_valid) begin
                        r_checksum <= r_checksum ^ i_rx_data;
                        if (w_word_complete) begin
                            r_mem_write   <= 1'b1;
                            r_mem_address <= w_word_address;
                            r_mem_wdata   <= w_word;
                            r_state       <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // The strobe lasts this single cycle; advance to the next word.
                    r_word_index <= w_next_index;
                    r_state      <= (w_next_index == r_len) ? ST_CHECK : ST_DATA;
                end
                ST_CHECK: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == r_checksum) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rx_ready    = w_rx_ready;
    assign o_mem_write   = r_mem_write;
    assign o_mem_address = r_mem_address;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_cpu_hold    = r_cpu_hold;
    assign o_done        = r_done;
    assign o_error       = r_error;

endmodule
`default_nettype wire
